// File: rtl/murax_pll_pkg.sv
// rtl/murax_pll_pkg.sv - PLL lock sequencer states and counter-width helpers.
package murax_pll_pkg;

  typedef enum logic [2:0] {
    S_PLLRST    = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4,
    S_BYPASS    = 3'd5
  } pll_state_e;

  // Bits needed to hold 0..max_val without wrapping.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// rtl/pll_lock_filter.sv - PLL LOCK synchronizer and saturating lock qualifier.
module pll_lock_filter
  import murax_pll_pkg::*;
#(
  parameter int LOCK_FILTER = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lock_raw,
  output logic lock_f_next
);

  localparam int FW = cnt_width(LOCK_FILTER);
  localparam logic [FW-1:0] FILTER_MAX = FW'(LOCK_FILTER);

  logic          sync1;
  logic          sync2;
  logic [FW-1:0] cnt;
  logic [FW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt;
    if (!sync2) begin
      cnt_next = '0;
    end else if (cnt != FILTER_MAX) begin
      cnt_next = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= lock_raw;
      sync2 <= sync1;
      cnt   <= cnt_next;
    end
  end

  // Value lock_f takes at the coming edge, so the sequencer changes state
  // on the same edge that lock_f itself rises or falls.
  assign lock_f_next = (cnt_next == FILTER_MAX);

endmodule

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - iCE40 PLL reset/lock supervisor; PLL_BYPASS_FALLBACK_EN enables bypass fallback.
module pll_lock_sequencer
  import murax_pll_pkg::*;
#(
  parameter int PLL_RESET_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 10000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int LOCK_FILTER         = 4
) (
  input  logic                               io_mainClk,
  input  logic                               io_asyncReset_n,
  input  logic                               pll_lock_raw,
  input  logic                               restart,
  output logic                               pll_resetb,
  output logic                               pll_bypass,
  output logic                               core_reset_n,
  output logic                               locked,
  output logic                               fail,
  output logic [cnt_width(MAX_RETRIES)-1:0]  retry_cnt,
  output logic                               lost_lock
);

  localparam int RW = cnt_width(MAX_RETRIES);
  localparam int TW = max_int(max_int(cnt_width(PLL_RESET_CYCLES), cnt_width(LOCK_TIMEOUT_CYCLES)),
                              cnt_width(LOCK_STABLE_CYCLES));

  localparam logic [TW-1:0] RST_LAST    = TW'(PLL_RESET_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

`ifdef PLL_BYPASS_FALLBACK_EN
  localparam logic [TW-1:0]  RST_FULL  = TW'(PLL_RESET_CYCLES);
  localparam pll_state_e     EXHAUSTED = S_BYPASS;
`else
  localparam pll_state_e     EXHAUSTED = S_FAIL;
`endif

  pll_state_e    state;
  pll_state_e    state_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic [RW-1:0] retry_next;
  logic          lock_f_next;
  logic          resetb_next;
  logic          bypass_next;
  logic          core_next;
  logic          locked_next;
  logic          fail_next;
  logic          lost_next;

  pll_lock_filter #(
    .LOCK_FILTER(LOCK_FILTER)
  ) u_lock_filter (
    .clk        (io_mainClk),
    .rst_n      (io_asyncReset_n),
    .lock_raw   (pll_lock_raw),
    .lock_f_next(lock_f_next)
  );

  always_comb begin
    state_next = state;
    timer_next = timer;
    retry_next = retry_cnt;
    lost_next  = 1'b0;

    if (restart) begin
      state_next = S_PLLRST;
      retry_next = '0;
    end else begin
      case (state)
        S_PLLRST: begin
          if (timer == RST_LAST) state_next = S_WAIT_LOCK;
          else                   timer_next = timer + 1'b1;
        end
        S_WAIT_LOCK: begin
          // A lock arriving in the timeout cycle takes precedence.
          if (lock_f_next) begin
            state_next = S_STABLE;
          end else if (timer == TIMEOUT_LAST) begin
            if (retry_cnt == RETRY_MAX) begin
              state_next = EXHAUSTED;
            end else begin
              retry_next = retry_cnt + 1'b1;
              state_next = S_PLLRST;
            end
          end else begin
            timer_next = timer + 1'b1;
          end
        end
        S_STABLE: begin
          if (!lock_f_next) begin
            state_next = S_WAIT_LOCK;
          end else if (timer == STABLE_LAST) begin
            state_next = S_RUN;
            retry_next = '0;
          end else begin
            timer_next = timer + 1'b1;
          end
        end
        S_RUN: begin
          if (!lock_f_next) begin
            lost_next  = 1'b1;
            state_next = S_PLLRST;
          end
        end
        S_FAIL: begin
          state_next = S_FAIL;
        end
`ifdef PLL_BYPASS_FALLBACK_EN
        S_BYPASS: begin
          if (timer != RST_FULL) timer_next = timer + 1'b1;
        end
`endif
        default: begin
          state_next = S_PLLRST;
        end
      endcase
    end

    if (restart || (state_next != state)) timer_next = '0;

    // Outputs are registered, so they are decoded from the next state.
    resetb_next = (state_next == S_WAIT_LOCK) || (state_next == S_STABLE) ||
                  (state_next == S_RUN);
    locked_next = (state_next == S_RUN);
`ifdef PLL_BYPASS_FALLBACK_EN
    bypass_next = (state_next == S_BYPASS);
    fail_next   = (state_next == S_FAIL) || (state_next == S_BYPASS);
    core_next   = (state_next == S_RUN) ||
                  ((state_next == S_BYPASS) && (timer_next == RST_FULL));
`else
    bypass_next = 1'b0;
    fail_next   = (state_next == S_FAIL);
    core_next   = (state_next == S_RUN);
`endif
  end

  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) begin
      state        <= S_PLLRST;
      timer        <= '0;
      retry_cnt    <= '0;
      pll_resetb   <= 1'b0;
      pll_bypass   <= 1'b0;
      core_reset_n <= 1'b0;
      locked       <= 1'b0;
      fail         <= 1'b0;
      lost_lock    <= 1'b0;
    end else begin
      state        <= state_next;
      timer        <= timer_next;
      retry_cnt    <= retry_next;
      pll_resetb   <= resetb_next;
      pll_bypass   <= bypass_next;
      core_reset_n <= core_next;
      locked       <= locked_next;
      fail         <= fail_next;
      lost_lock    <= lost_next;
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - scoreboard bench for pll_lock_sequencer.
module tb_pll_lock_sequencer;

  localparam int PRC = 4;
  localparam int LTO = 20;
  localparam int LST = 8;
  localparam int MR  = 2;
  localparam int LF  = 2;

  localparam int SIG_RESETB = 0, SIG_BYPASS = 1, SIG_CORE = 2, SIG_LOCKED = 3,
                 SIG_FAIL = 4, SIG_RETRY = 5, SIG_LOST = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lock_raw = 1'b0;
  logic       restart = 1'b0;
  logic       pll_resetb, pll_bypass, core_reset_n, locked, fail, lost_lock;
  logic [1:0] retry_cnt;

  int cyc;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    int         sig;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];

  pll_lock_sequencer #(
    .PLL_RESET_CYCLES   (PRC),
    .LOCK_TIMEOUT_CYCLES(LTO),
    .LOCK_STABLE_CYCLES (LST),
    .MAX_RETRIES        (MR),
    .LOCK_FILTER        (LF)
  ) dut (
    .io_mainClk     (clk),
    .io_asyncReset_n(rst_n),
    .pll_lock_raw   (lock_raw),
    .restart        (restart),
    .pll_resetb     (pll_resetb),
    .pll_bypass     (pll_bypass),
    .core_reset_n   (core_reset_n),
    .locked         (locked),
    .fail           (fail),
    .retry_cnt      (retry_cnt),
    .lost_lock      (lost_lock)
  );

  always #5 clk = ~clk;

  // Edge number since the last reset release; edge 1 is the first posedge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic string sig_name(input int s);
    case (s)
      SIG_RESETB: return "pll_resetb";
      SIG_BYPASS: return "pll_bypass";
      SIG_CORE:   return "core_reset_n";
      SIG_LOCKED: return "locked";
      SIG_FAIL:   return "fail";
      SIG_RETRY:  return "retry_cnt";
      SIG_LOST:   return "lost_lock";
      default:    return "unknown";
    endcase
  endfunction

  function logic [7:0] sig_val(input int s);
    case (s)
      SIG_RESETB: return {7'd0, pll_resetb};
      SIG_BYPASS: return {7'd0, pll_bypass};
      SIG_CORE:   return {7'd0, core_reset_n};
      SIG_LOCKED: return {7'd0, locked};
      SIG_FAIL:   return {7'd0, fail};
      SIG_RETRY:  return {6'd0, retry_cnt};
      SIG_LOST:   return {7'd0, lost_lock};
      default:    return 8'hxx;
    endcase
  endfunction

  task automatic expect_at(input int c, input int s, input int v);
    exp_t e;
    e.cyc = c;
    e.sig = s;
    e.val = 8'(v);
    exp_q.push_back(e);
  endtask

  task automatic expect_reset_values();
    for (int s = 0; s <= SIG_LOST; s++) expect_at(0, s, 0);
  endtask

  // Monitor: on every falling edge, retire the expectations due at this edge.
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        checks++;
        if (sig_val(exp_q[i].sig) !== exp_q[i].val) begin
          failures++;
          $display("FAIL %s at edge %0d: got %0d, expected %0d",
                   sig_name(exp_q[i].sig), cyc, sig_val(exp_q[i].sig), exp_q[i].val);
        end
        exp_q.delete(i);
      end
    end
  end

  task automatic at_edge(input int k);
    int guard;
    guard = 0;
    while (cyc < k && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checks++;
    if (cyc < k) begin
      failures++;
      $display("FAIL wait_edge: reached edge %0d, required %0d", cyc, k);
    end
  endtask

  task automatic reset_dut();
    rst_n    = 1'b0;
    lock_raw = 1'b0;
    restart  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state, nominal lock, then loss of lock in S_RUN.
    expect_reset_values();
    reset_dut();
    expect_at(3, SIG_RESETB, 0);
    expect_at(4, SIG_RESETB, 1);
    expect_at(20, SIG_CORE, 0);
    expect_at(20, SIG_LOCKED, 0);
    expect_at(21, SIG_CORE, 1);
    expect_at(21, SIG_LOCKED, 1);
    expect_at(21, SIG_RETRY, 0);
    expect_at(27, SIG_LOST, 0);
    expect_at(27, SIG_CORE, 1);
    expect_at(28, SIG_LOST, 1);
    expect_at(28, SIG_CORE, 0);
    expect_at(28, SIG_LOCKED, 0);
    expect_at(28, SIG_RESETB, 0);
    expect_at(28, SIG_RETRY, 0);
    expect_at(29, SIG_LOST, 0);
    expect_at(31, SIG_RESETB, 0);
    expect_at(32, SIG_RESETB, 1);
    at_edge(9);
    lock_raw = 1'b1;
    at_edge(25);
    lock_raw = 1'b0;
    at_edge(33);

    // One-cycle lock glitch late in the stable window.
    reset_dut();
    expect_at(20, SIG_CORE, 0);
    expect_at(21, SIG_CORE, 0);
    expect_at(21, SIG_RESETB, 1);
    expect_at(25, SIG_RETRY, 0);
    expect_at(30, SIG_CORE, 0);
    expect_at(30, SIG_LOCKED, 0);
    expect_at(31, SIG_CORE, 1);
    expect_at(31, SIG_LOCKED, 1);
    at_edge(9);
    lock_raw = 1'b1;
    at_edge(18);
    lock_raw = 1'b0;
    at_edge(19);
    lock_raw = 1'b1;
    at_edge(32);

    // Lock never arrives: two retries, then exhaustion, restart, async reset.
    reset_dut();
    expect_at(4, SIG_RESETB, 1);
    expect_at(23, SIG_RESETB, 1);
    expect_at(23, SIG_RETRY, 0);
    expect_at(24, SIG_RESETB, 0);
    expect_at(24, SIG_RETRY, 1);
    expect_at(27, SIG_RESETB, 0);
    expect_at(28, SIG_RESETB, 1);
    expect_at(47, SIG_RESETB, 1);
    expect_at(48, SIG_RESETB, 0);
    expect_at(48, SIG_RETRY, 2);
    expect_at(52, SIG_RESETB, 1);
    expect_at(71, SIG_RESETB, 1);
    expect_at(71, SIG_FAIL, 0);
    expect_at(72, SIG_RESETB, 0);
    expect_at(72, SIG_FAIL, 1);
    expect_at(75, SIG_CORE, 0);
    expect_at(79, SIG_RESETB, 0);
    expect_at(79, SIG_FAIL, 1);
    expect_at(79, SIG_RETRY, 2);
`ifdef PLL_BYPASS_FALLBACK_EN
    expect_at(72, SIG_BYPASS, 1);
    expect_at(76, SIG_CORE, 1);
    expect_at(79, SIG_CORE, 1);
    expect_at(79, SIG_BYPASS, 1);
`else
    expect_at(50, SIG_BYPASS, 0);
    expect_at(72, SIG_BYPASS, 0);
    expect_at(79, SIG_CORE, 0);
    expect_at(79, SIG_BYPASS, 0);
`endif
    expect_at(80, SIG_FAIL, 0);
    expect_at(80, SIG_RESETB, 0);
    expect_at(80, SIG_RETRY, 0);
    expect_at(80, SIG_BYPASS, 0);
    expect_at(80, SIG_CORE, 0);
    expect_at(83, SIG_RESETB, 0);
    expect_at(84, SIG_RESETB, 1);
    expect_at(91, SIG_RESETB, 1);
    expect_at(91, SIG_CORE, 0);
    at_edge(79);
    restart = 1'b1;
    at_edge(80);
    restart = 1'b0;
    at_edge(85);
    lock_raw = 1'b1;
    at_edge(92);
    #1;
    expect_reset_values();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    while (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL unchecked %s: due at edge %0d, expected %0d",
               sig_name(exp_q[0].sig), exp_q[0].cyc, exp_q[0].val);
      void'(exp_q.pop_front());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
